mapper_mem_arbiter: RTL and testbench

MAPPER_MEM_ARBITER -- requirements
Module: mapper_mem_arbiter

---
 rtl/mapper_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mapper_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_mem_arbiter.sv
// Shares one external memory port between PPU CHR reads, CPU PRG accesses and the ROM loader.
// Latency: request-to-ack of 4 cycles minimum (IDLE, ISSUE, WAIT, DONE), longer while memory is slow.
// Backpressure: requests are held until their one-cycle ack; WAIT ends on mem_ready or after TIMEOUT cycles.
// Build option: define MAPPER_ARB_LOADER_EN to let the loader port arbitrate at lowest priority.
module mapper_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  // PPU CHR read port
  input  logic        i_ppu_req,
  input  logic [21:0] i_ppu_addr,
  output logic        o_ppu_ack,
  // CPU PRG port
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [21:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  // ROM loader write port
  input  logic        i_ldr_req,
  input  logic [21:0] i_ldr_addr,
  input  logic [7:0]  i_ldr_wdata,
  output logic        o_ldr_ack,
  // read data for the requester being acked
  output logic [7:0]  o_rdata,
  // external memory
  output logic [21:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {W_PPU, W_CPU, W_LDR} winner_t;

  state_t          r_state;
  state_t          w_state_nxt;
  winner_t         r_winner;
  winner_t         w_grant;
  logic            w_grant_vld;
  logic            w_cpu_first;
  logic            w_ldr_vld;
  logic            w_timeout;
  logic            r_we;
  logic [21:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_wait_cnt;
  logic            r_timeout_err;

`ifdef MAPPER_ARB_LOADER_EN
  assign w_ldr_vld = i_ldr_req;
`else
  // Loader port is inert in this build; its request is deliberately dropped.
  logic w_ldr_unused;
  assign w_ldr_vld    = 1'b0;
  assign w_ldr_unused = i_ldr_req;
`endif

  assign w_timeout = (r_wait_cnt == TW'(TIMEOUT - 1));

  // Pick a winner: PPU first, unless the CPU has been passed over too often; loader last.
  always_comb begin
    w_grant     = W_PPU;
    w_cpu_first = i_cpu_req && (!i_ppu_req || (r_starve >= SW'(STARVE_LIMIT)));
    w_grant_vld = i_ppu_req | i_cpu_req | w_ldr_vld;
    if (w_cpu_first) begin
      w_grant = W_CPU;
    end else if (i_ppu_req) begin
      w_grant = W_PPU;
    end else if (w_ldr_vld) begin
      w_grant = W_LDR;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus strobe/ack decode from the registered state.
  always_comb begin
    w_state_nxt = r_state;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_ppu_ack   = 1'b0;
    o_cpu_ack   = 1'b0;
    o_ldr_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_mem_rd    = !r_we;
        o_mem_wr    = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // mem_ready wins over a timeout landing in the same cycle.
        if (i_mem_ready || w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_ppu_ack   = (r_winner == W_PPU);
        o_cpu_ack   = (r_winner == W_CPU);
`ifdef MAPPER_ARB_LOADER_EN
        o_ldr_ack   = (r_winner == W_LDR);
`endif
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the winning command in IDLE, track starvation, collect read data or time out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_winner      <= W_PPU;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_starve      <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_vld) begin
            r_winner <= w_grant;
            case (w_grant)
              W_CPU: begin
                r_we    <= i_cpu_we;
                r_addr  <= i_cpu_addr;
                r_wdata <= i_cpu_wdata;
              end
              W_LDR: begin
                r_we    <= 1'b1;
                r_addr  <= i_ldr_addr;
                r_wdata <= i_ldr_wdata;
              end
              default: begin
                r_we    <= 1'b0;
                r_addr  <= i_ppu_addr;
                r_wdata <= '0;
              end
            endcase
            if (w_grant == W_CPU) begin
              r_starve <= '0;
            end else if ((w_grant == W_PPU) && i_cpu_req && (r_starve < SW'(STARVE_LIMIT))) begin
              r_starve <= r_starve + 1'b1;
            end
          end
        end
        WAIT: begin
          if (i_mem_ready) begin
            if (!r_we) begin
              r_rdata <= i_mem_rdata;
            end
          end else if (w_timeout) begin
            r_rdata       <= 8'hFF;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_rdata       = r_rdata;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Directed bench for mapper_mem_arbiter: scoreboard of expected acks plus a simple memory model.
// Memory model answers each strobe after mem_lat WAIT cycles (mem_lat < 0 means never).
// Ack monitor pops the scoreboard and checks requester, rdata and address stability.
module tb_mapper_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_ppu_req = 1'b0;
  logic [21:0] i_ppu_addr = '0;
  logic        o_ppu_ack;
  logic        i_cpu_req = 1'b0;
  logic        i_cpu_we = 1'b0;
  logic [21:0] i_cpu_addr = '0;
  logic [7:0]  i_cpu_wdata = '0;
  logic        o_cpu_ack;
  logic        i_ldr_req = 1'b0;
  logic [21:0] i_ldr_addr = '0;
  logic [7:0]  i_ldr_wdata = '0;
  logic        o_ldr_ack;
  logic [7:0]  o_rdata;
  logic [21:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_ready;
  logic        o_timeout_err;

  mapper_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_ppu_req(i_ppu_req), .i_ppu_addr(i_ppu_addr), .o_ppu_ack(o_ppu_ack),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack),
    .i_ldr_req(i_ldr_req), .i_ldr_addr(i_ldr_addr), .i_ldr_wdata(i_ldr_wdata),
    .o_ldr_ack(o_ldr_ack),
    .o_rdata(o_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;    // 0 PPU, 1 CPU, 2 loader
    logic [7:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mdata(input logic [21:0] a);
    return a[7:0] ^ 8'h4A;
  endfunction

  // ---------------- memory model ----------------
  int          mem_lat = 0;
  logic        model_ready = 1'b0;
  logic [7:0]  model_rdata = '0;
  logic        stray_ready = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [21:0] pend_addr = '0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [21:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;

  assign i_mem_ready = model_ready | stray_ready;
  assign i_mem_rdata = model_rdata;

  always @(negedge clk) begin
    if (reset) begin
      pend        = 1'b0;
      model_ready = 1'b0;
    end else begin
      model_ready = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          model_ready = 1'b1;
          model_rdata = mdata(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (o_mem_rd || o_mem_wr) begin
        if (o_mem_rd) n_rd++;
        else          n_wr++;
        last_addr  = o_mem_addr;
        last_wdata = o_mem_wdata;
        if (mem_lat >= 0) begin
          pend      = 1'b1;
          pend_cnt  = mem_lat;
          pend_addr = o_mem_addr;
        end
      end
    end
  end

  // ---------------- ack monitor / scoreboard ----------------
  int   mon_na;
  int   mon_who;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      mon_na = int'(o_ppu_ack) + int'(o_cpu_ack) + int'(o_ldr_ack);
      if (mon_na != 0) begin
        check("acks_onehot", mon_na, 1);
        check("ack_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e   = sb.pop_front();
          mon_who = o_cpu_ack ? 1 : (o_ldr_ack ? 2 : 0);
          check("ack_who", mon_who, mon_e.who);
          check("ack_rdata", o_rdata, mon_e.rdata);
          check("addr_stable", o_mem_addr, last_addr);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic ackof(input int who);
    return (who == 0) ? o_ppu_ack : ((who == 1) ? o_cpu_ack : o_ldr_ack);
  endfunction

  // Called at the negedge where the request was driven (cycle 1); returns the cycle of the ack.
  task automatic wait_ack(input string tag, input int who, input int budget, output int k);
    logic seen;
    seen = 1'b0;
    k    = 1;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (ackof(who)) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acks"}, {o_ppu_ack, o_cpu_ack, o_ldr_ack}, 3'b000);
    check({tag, "_strobes"}, {o_mem_rd, o_mem_wr}, 2'b00);
    check({tag, "_rdata"}, o_rdata, 8'h00);
    check({tag, "_mem_addr"}, o_mem_addr, 22'h0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 8'h00);
    check({tag, "_timeout_err"}, o_timeout_err, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  int k;
  int rd0;
  int wr0;
  int gap;
  int ncpu;
  int gaps[2];
  int lacks;

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    // PPU read, memory answers in the first WAIT cycle.
    mem_lat = 0;
    rd0 = n_rd;
    i_ppu_req  = 1'b1;
    i_ppu_addr = 22'h200010;
    sb.push_back('{who: 0, rdata: 8'h5A});
    wait_ack("ppu_rd_ack", 0, 40, k);
    i_ppu_req = 1'b0;
    check("ppu_rd_latency", k, 4);
    check("ppu_rd_rdata", o_rdata, 8'h5A);
    check("ppu_rd_addr", last_addr, 22'h200010);
    check("ppu_rd_strobes", n_rd - rd0, 1);
    @(negedge clk);
    check("rdata_held", o_rdata, 8'h5A);

    // CPU write; request inputs scrambled after latch must not leak into the access.
    rd0 = n_rd; wr0 = n_wr;
    i_cpu_req   = 1'b1;
    i_cpu_we    = 1'b1;
    i_cpu_addr  = 22'h001234;
    i_cpu_wdata = 8'hC3;
    sb.push_back('{who: 1, rdata: 8'h5A});
    @(negedge clk);
    i_cpu_addr  = 22'h3FFFFF;
    i_cpu_wdata = 8'h00;
    i_cpu_we    = 1'b0;
    wait_ack("cpu_wr_ack", 1, 40, k);
    i_cpu_req = 1'b0;
    check("cpu_wr_strobes", n_wr - wr0, 1);
    check("cpu_wr_no_rd", n_rd - rd0, 0);
    check("cpu_wr_addr", last_addr, 22'h001234);
    check("cpu_wr_wdata", last_wdata, 8'hC3);
    check("cpu_wr_held_wdata", o_mem_wdata, 8'hC3);

    // Stray mem_ready while idle must be ignored.
    @(negedge clk);
    stray_ready = 1'b1;
    repeat (2) @(negedge clk);
    stray_ready = 1'b0;
    check("stray_ready_rdata", o_rdata, 8'h5A);
    check("stray_ready_err", o_timeout_err, 1'b0);

    // CPU read with a slower memory (ready in third WAIT cycle).
    mem_lat = 2;
    i_cpu_req  = 1'b1;
    i_cpu_we   = 1'b0;
    i_cpu_addr = 22'h000077;
    sb.push_back('{who: 1, rdata: 8'h3D});
    wait_ack("cpu_rd_ack", 1, 40, k);
    i_cpu_req = 1'b0;
    check("cpu_rd_latency", k, 6);
    check("cpu_rd_rdata", o_rdata, 8'h3D);

    // Starvation: both requesters held; CPU wins after every 8 PPU grants.
    mem_lat = 0;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 8; p++) sb.push_back('{who: 0, rdata: mdata(22'h2000A0)});
      sb.push_back('{who: 1, rdata: mdata(22'h000123)});
    end
    i_ppu_req  = 1'b1;
    i_ppu_addr = 22'h2000A0;
    i_cpu_req  = 1'b1;
    i_cpu_we   = 1'b0;
    i_cpu_addr = 22'h000123;
    gap = 0; ncpu = 0; k = 0;
    while (ncpu < 2 && k < 400) begin
      @(negedge clk);
      k++;
      if (o_ppu_ack) gap++;
      if (o_cpu_ack) begin
        gaps[ncpu] = gap;
        ncpu++;
        gap = 0;
      end
    end
    i_ppu_req = 1'b0;
    i_cpu_req = 1'b0;
    check("starve_cpu_grants", ncpu, 2);
    check("starve_gap_first", gaps[0], 8);
    check("starve_gap_after_clear", gaps[1], 8);

    // Timeout: memory never answers.
    @(negedge clk);
    check("err_before_timeout", o_timeout_err, 1'b0);
    mem_lat = -1;
    i_ppu_req  = 1'b1;
    i_ppu_addr = 22'h000055;
    sb.push_back('{who: 0, rdata: 8'hFF});
    wait_ack("tmo_ack", 0, 60, k);
    i_ppu_req = 1'b0;
    check("tmo_latency", k, 18);
    check("tmo_rdata", o_rdata, 8'hFF);
    check("tmo_err_set", o_timeout_err, 1'b1);

    // Error flag survives a normal transaction.
    mem_lat = 0;
    @(negedge clk);
    i_ppu_req  = 1'b1;
    i_ppu_addr = 22'h000033;
    sb.push_back('{who: 0, rdata: 8'h79});
    wait_ack("post_tmo_ack", 0, 40, k);
    i_ppu_req = 1'b0;
    check("tmo_err_sticky", o_timeout_err, 1'b1);

    do_reset();
    check_reset_state("reset2");

    // mem_ready arrives in the very last WAIT cycle: treated as success.
    mem_lat = 14;
    i_cpu_req  = 1'b1;
    i_cpu_we   = 1'b0;
    i_cpu_addr = 22'h0000C8;
    sb.push_back('{who: 1, rdata: mdata(22'h0000C8)});
    wait_ack("edge_ready_ack", 1, 60, k);
    i_cpu_req = 1'b0;
    check("edge_ready_latency", k, 18);
    check("edge_ready_err", o_timeout_err, 1'b0);
    check("edge_ready_rdata", o_rdata, 8'h82);

    // Reset during WAIT of a CPU read abandons it.
    mem_lat = -1;
    @(negedge clk);
    i_cpu_req  = 1'b1;
    i_cpu_addr = 22'h000400;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    i_cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("midtxn_reset");
    rd0 = n_rd; wr0 = n_wr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_reset_quiet", {o_mem_rd, o_mem_wr, o_cpu_ack}, 3'b000);
    end
    check("post_reset_no_strobe", (n_rd - rd0) + (n_wr - wr0), 0);

    // Loader port.
    mem_lat = 0;
    wr0 = n_wr;
    lacks = 0;
    i_ldr_req   = 1'b1;
    i_ldr_addr  = 22'h3F0000;
    i_ldr_wdata = 8'h01;
`ifdef MAPPER_ARB_LOADER_EN
    sb.push_back('{who: 2, rdata: 8'h00});
    wait_ack("ldr_ack", 2, 40, k);
    i_ldr_req = 1'b0;
    check("ldr_latency", k, 4);
    check("ldr_wr_strobes", n_wr - wr0, 1);
    check("ldr_addr", last_addr, 22'h3F0000);
    check("ldr_wdata", last_wdata, 8'h01);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_ldr_ack) lacks++;
    end
    i_ldr_req = 1'b0;
    check("ldr_disabled_ack", lacks, 0);
    check("ldr_disabled_wr", n_wr - wr0, 0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
